// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: two-flop synchronisers, per-channel debounce,
// and Gray-code decode into one-cycle detent pulses plus an illegal-edge error.
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGES_PER_STEP  = 4,
  parameter bit DIR_INVERT      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       step_up,
  output logic       step_dn,
  output logic       err,
  output logic [1:0] phase,
  output logic       ready
);

  localparam logic [7:0]        DEB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0]        DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [2:0] ACC_MAX  = 3'(EDGES_PER_STEP - 1);
  localparam logic signed [2:0] ACC_MIN  = -ACC_MAX;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        enc, sync_bits, filt_bits, init_full;
  logic [1:0]        prev_reg, fill_reg, edge_delta;
  logic              sync_valid, init_load;
  logic signed [2:0] acc_reg, acc_next;
  logic              step_up_reg, step_dn_reg, err_reg, ready_reg;
  logic              step_up_next, step_dn_next, err_next, ready_next;
  logic              up_evt, dn_evt;

  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  assign enc        = {enc_a, enc_b};
  // The sync chain holds reset zeros for two cycles; ignore them during INIT.
  assign sync_valid = fill_reg[1];
  assign init_load  = (state_reg == S_INIT) && (&init_full);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic       meta_reg, sync_reg, filt_reg;
      logic [7:0] cnt_reg, stable_next;

      // INIT: run length of identical valid samples, saturating at DEB_MAX.
      always_comb begin
        stable_next = '0;
        if (sync_valid) begin
          if (cnt_reg != '0 && sync_reg == prev_reg[gi])
            stable_next = (cnt_reg == DEB_MAX) ? DEB_MAX : cnt_reg + 8'd1;
          else
            stable_next = 8'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          filt_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= enc[gi];
          sync_reg <= meta_reg;
          if (state_reg == S_INIT) begin
            if (init_load) begin
              filt_reg <= sync_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= stable_next;
            end
          end else if (sync_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            filt_reg <= sync_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end

      assign sync_bits[gi] = sync_reg;
      assign filt_bits[gi] = filt_reg;
      assign init_full[gi] = (stable_next == DEB_MAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (init_load) state_next = S_RUN;
  end

  assign edge_delta = gray_idx(filt_bits) - gray_idx(prev_reg);

  always_comb begin
    acc_next = acc_reg;
    up_evt   = 1'b0;
    dn_evt   = 1'b0;
    err_next = 1'b0;
    if (state_reg == S_RUN) begin
      unique case (edge_delta)
        2'd1: begin
          if (acc_reg == ACC_MAX) begin
            up_evt   = 1'b1;
            acc_next = '0;
          end else begin
            acc_next = acc_reg + 3'sd1;
          end
        end
        2'd3: begin
          if (acc_reg == ACC_MIN) begin
            dn_evt   = 1'b1;
            acc_next = '0;
          end else begin
            acc_next = acc_reg - 3'sd1;
          end
        end
        2'd2: begin
          err_next = 1'b1;
          acc_next = '0;
        end
        default: ;
      endcase
    end
    step_up_next = DIR_INVERT ? dn_evt : up_evt;
    step_dn_next = DIR_INVERT ? up_evt : dn_evt;
    ready_next   = (state_next == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_reg    <= '0;
      prev_reg    <= '0;
      acc_reg     <= '0;
      step_up_reg <= 1'b0;
      step_dn_reg <= 1'b0;
      err_reg     <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      fill_reg    <= {fill_reg[0], 1'b1};
      // During INIT prev tracks the raw synchronised value as the stability reference.
      prev_reg    <= (state_reg == S_RUN) ? filt_bits : sync_bits;
      acc_reg     <= acc_next;
      step_up_reg <= step_up_next;
      step_dn_reg <= step_dn_next;
      err_reg     <= err_next;
      ready_reg   <= ready_next;
    end
  end

  assign step_up = step_up_reg;
  assign step_dn = step_dn_reg;
  assign err     = err_reg;
  assign phase   = filt_bits;
  assign ready   = ready_reg;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: three decoders (4 edges/step, inverted direction, 1 edge/step)
// share one encoder; expected pulses are queued with their due cycle at drive time.
module tb_quad_step_decoder;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  typedef struct {
    int code;
    int t;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       up [3];
  logic       dn [3];
  logic       er [3];
  logic       rdy [3];
  logic [1:0] ph [3];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_m = 0;
  logic [1:0] cur_ab = 2'b00;
  ev_t        q0[$];
  ev_t        q1[$];
  ev_t        q2[$];

  quad_step_decoder #(.DEBOUNCE_CYCLES(DEB), .EDGES_PER_STEP(4), .DIR_INVERT(1'b0)) u_main (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .step_up(up[0]), .step_dn(dn[0]), .err(er[0]), .phase(ph[0]), .ready(rdy[0])
  );
  quad_step_decoder #(.DEBOUNCE_CYCLES(DEB), .EDGES_PER_STEP(4), .DIR_INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .step_up(up[1]), .step_dn(dn[1]), .err(er[1]), .phase(ph[1]), .ready(rdy[1])
  );
  quad_step_decoder #(.DEBOUNCE_CYCLES(DEB), .EDGES_PER_STEP(1), .DIR_INVERT(1'b0)) u_e1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .step_up(up[2]), .step_dn(dn[2]), .err(er[2]), .phase(ph[2]), .ready(rdy[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // codes: 1 = step_up, 2 = step_dn, 4 = err
  task automatic push(input int id, input int code, input int t);
    ev_t e;
    e.code = code;
    e.t    = t;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model(input logic [1:0] from, input logic [1:0] to, input int t);
    int d;
    d = (gidx(to) - gidx(from) + 4) % 4;
    if (d == 2) begin
      acc_m = 0;
      for (int i = 0; i < 3; i++) push(i, 4, t);
    end else if (d == 1) begin
      push(2, 1, t);
      if (acc_m == 3) begin
        acc_m = 0;
        push(0, 1, t);
        push(1, 2, t);
      end else begin
        acc_m++;
      end
    end else if (d == 3) begin
      push(2, 2, t);
      if (acc_m == -3) begin
        acc_m = 0;
        push(0, 2, t);
        push(1, 1, t);
      end else begin
        acc_m--;
      end
    end
  endtask

  task automatic mon(input int id);
    ev_t e;
    int  code;
    bit  due;
    code = int'({er[id], dn[id], up[id]});
    due  = 1'b0;
    case (id)
      0: if (q0.size() > 0 && q0[0].t == cyc) begin e = q0.pop_front(); due = 1'b1; end
      1: if (q1.size() > 0 && q1[0].t == cyc) begin e = q1.pop_front(); due = 1'b1; end
      default: if (q2.size() > 0 && q2[0].t == cyc) begin e = q2.pop_front(); due = 1'b1; end
    endcase
    if (due) check($sformatf("pulse_kind%0d", id), code, e.code);
    else if (code != 0) check($sformatf("unexpected_pulse%0d", id), code, 0);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic drive(input logic [1:0] ab);
    $display("drive ab=%b from %b at cyc %0d", ab, cur_ab, cyc);
    model(cur_ab, ab, cyc + 3 + DEB);
    {enc_a, enc_b} = ab;
    cur_ab = ab;
    repeat (HOLD) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("phase%0d", i), int'(ph[i]), int'(ab));
  endtask

  task automatic do_reset(input logic [1:0] ab, input int cycles);
    $display("reset with ab=%b for %0d cycles at cyc %0d", ab, cycles, cyc);
    {enc_a, enc_b} = ab;
    cur_ab = ab;
    acc_m  = 0;
    rst    = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (cycles) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_up%0d", i), int'(up[i]), 0);
      check($sformatf("rst_dn%0d", i), int'(dn[i]), 0);
      check($sformatf("rst_err%0d", i), int'(er[i]), 0);
      check($sformatf("rst_ready%0d", i), int'(rdy[i]), 0);
      check($sformatf("rst_phase%0d", i), int'(ph[i]), 0);
    end
    rst = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("init_ready%0d", i), int'(rdy[i]), 1);
      check($sformatf("init_phase%0d", i), int'(ph[i]), int'(ab));
    end
  endtask

  initial begin
    do_reset(2'b11, 3);
    do_reset(2'b00, 2);

    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);

    // 3-cycle glitch on A must be rejected entirely
    $display("glitch enc_a for 3 cycles at cyc %0d", cyc);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("glitch_phase%0d", i), int'(ph[i]), 0);
    drive(2'b10); drive(2'b00);

    // illegal jump mid-detent clears the accumulator
    drive(2'b01); drive(2'b11); drive(2'b00);
    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);

    // partial detent discarded by reset
    drive(2'b01); drive(2'b11);
    do_reset(2'b11, 1);
    drive(2'b10); drive(2'b00); drive(2'b01); drive(2'b11);

    repeat (20) @(negedge clk);
    check("left_q0", q0.size(), 0);
    check("left_q1", q1.size(), 0);
    check("left_q2", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream front end for each paddle encoder. Sits between the raw encoder pins and the paddle-position logic.
- Synchronises and debounces the two quadrature lines (A, B) and decodes the Gray-code sequence.
- Emits clean one-cycle step_up/step_dn pulses, one per detent, plus an illegal-transition error pulse.
- Two instances in the design: paddle 1 and paddle 2.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (legal 1..255).
- EDGES_PER_STEP, 4, legal quadrature edges per output step (legal 1, 2, 4).
- DIR_INVERT, 0, 1 swaps step_up and step_dn.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- enc_a  input  1  raw encoder channel A, asynchronous
- enc_b  input  1  raw encoder channel B, asynchronous
- step_up  output  1  one-cycle pulse, one detent forward
- step_dn  output  1  one-cycle pulse, one detent reverse
- err  output  1  one-cycle pulse, illegal transition (both bits changed)
- phase  output  2  current filtered state {A,B}
- ready  output  1  high once INIT completes

Behaviour:
- One clock; reset is synchronous and active-high. While rst=1 on a clk edge, every register clears:
  - sync flops, debounce counters, filtered bits, edge accumulator, FSM go to INIT.
  - step_up=0, step_dn=0, err=0, phase=00, ready=0.
- Synchroniser: 2-flop chain per channel. Inputs are never sampled unsynchronised.
- Debounce, per channel:
  - Counter increments each cycle the sync value differs from the filtered value.
  - Counter clears on any cycle they are equal.
  - When counter reaches DEBOUNCE_CYCLES the filtered bit takes the sync value and the counter clears.
  - Latency, pin change to phase change: 2 + DEBOUNCE_CYCLES cycles.
- FSM states: INIT, RUN.
  - INIT: baseline load, no decode. Runs each channel's counter against the sync value until both channels have held stable for DEBOUNCE_CYCLES.
    - It then loads filtered = sync, prev = filtered, sets ready=1 and moves to RUN.
    - No pulse or err is produced in INIT, whatever the encoder rest position (00 or 11).
  - RUN: each cycle, compare new filtered {A,B} against prev, then set prev = new.
    - Forward edge (00→01→11→10→00) = +1.
    - Reverse edge = -1.
    - Unchanged = no action.
    - Both bits changed in the same cycle = illegal: err=1 for one cycle, accumulator cleared to 0, no step.
  - RUN → INIT only via rst.
- Edge accumulator: signed, range ±(EDGES_PER_STEP-1).
  - +1 edge with acc = EDGES_PER_STEP-1: pulse step_up, acc = 0; otherwise acc += 1.
  - -1 edge with acc = -(EDGES_PER_STEP-1): pulse step_dn, acc = 0; otherwise acc -= 1.
  - A direction reversal mid-detent walks acc back toward 0. No pulse until a full EDGES_PER_STEP net edges accumulate.
  - EDGES_PER_STEP=1: a pulse on every legal edge.
- Outputs are registered. The step or err pulse asserts the cycle after phase changes and lasts exactly one cycle.
- Exclusivity: step_up and step_dn are never high together; err is never high with either.
- DIR_INVERT=1 swaps the step outputs only. err, phase and the accumulator are unaffected.
- Reset mid-operation:
  - A partially accumulated detent is discarded.
  - A pending pulse is not emitted.
  - INIT re-runs.
- Maximum input rate: one legal edge per 2 + DEBOUNCE_CYCLES cycles. Faster input may merge edges into err; this is accepted behaviour.

Test Plan:
(DEBOUNCE_CYCLES=4, EDGES_PER_STEP=4, DIR_INVERT=0 unless stated)
- Reset release with enc={1,1} held → ready=1 by cycle 7 after rst falls, phase=11; step_up/step_dn/err stay 0 throughout.
- From rest 00, drive 01,11,10,00, each held 10 cycles → exactly one step_up pulse, 1 cycle after phase returns to 00; step_dn=0, err=0.
- From 00, drive 10,11,01,00 → exactly one step_dn pulse; repeat with DIR_INVERT=1 → step_up instead.
- From 00, pulse enc_a high for 3 cycles, then low → phase stays 00, no counter carry-over; a later 4-cycle-stable change does update.
- From 00 with acc=+2 (after 01,11), jump directly to 00 via simultaneous A/B change → err for one cycle.
  - Then 01,11,10: no step (acc=3).
  - Then 00: step_up.
- After 2 forward edges, assert rst for 1 cycle → outputs 0, ready=0; after re-INIT, 4 further forward edges required before step_up.
